// File: rtl/cep_define.sv
// Shared core definitions: PMP operation codes, PMP CSR addresses, pmpcfg layout
// and the PMP request scheduler's state and requester types.
package cep_define;

    typedef enum logic [1:0] {
        READ    = 2'b00,
        WRITE   = 2'b01,
        EXECUTE = 2'b10
    } oper_e;

    localparam logic [11:0] CSR_PMPCFG0  = 12'h3A0;
    localparam logic [11:0] CSR_PMPCFG1  = 12'h3A1;
    localparam logic [11:0] CSR_PMPCFG2  = 12'h3A2;
    localparam logic [11:0] CSR_PMPCFG3  = 12'h3A3;
    localparam logic [11:0] CSR_PMPADDR0 = 12'h3B0;

    typedef struct packed {
        logic       l;
        logic [1:0] reserved;
        logic [1:0] a;
        logic       x;
        logic       w;
        logic       r;
    } pmpcfg_t;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        CSR_WR,
        CSR_SETTLE
    } pmp_sched_state_e;

    typedef enum logic {
        REQ_IF  = 1'b0,
        REQ_LSU = 1'b1
    } req_id_e;

    localparam logic [1:0] PMP_PERM_ALLOW = 2'b11;

endpackage

// File: rtl/pmp_req_sched_rr_arb2.sv
// Two-requester round-robin arbiter; on a tie the requester that did not win
// last is granted. block suppresses all grants.
module rr_arb2
    import cep_define::*;
(
    input  logic clock,
    input  logic reset,
    input  logic req_if,
    input  logic req_lsu,
    input  logic block,
    output logic gnt_if,
    output logic gnt_lsu
);

    req_id_e last_grant;

    always_comb begin
        gnt_if  = 1'b0;
        gnt_lsu = 1'b0;
        if (!block) begin
            if (req_if && req_lsu) begin
                gnt_if  = (last_grant == REQ_LSU);
                gnt_lsu = (last_grant == REQ_IF);
            end else begin
                gnt_if  = req_if;
                gnt_lsu = req_lsu;
            end
        end
    end

    // Reset to LSU so that IF wins the first tie.
    always_ff @(posedge clock) begin
        if (!reset) begin
            last_grant <= REQ_LSU;
        end else if (gnt_if) begin
            last_grant <= REQ_IF;
        end else if (gnt_lsu) begin
            last_grant <= REQ_LSU;
        end
    end

endmodule

// File: rtl/pmp_req_sched.sv
// Shares one PMP checker between instruction fetch, the LSU and PMP CSR writes.
// All checker inputs and requester responses are registered.
module pmp_req_sched
    import cep_define::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [XLEN-1:0] if_addr,
    input  logic [1:0]      if_priv,
    output logic            if_rsp_valid,
    output logic            if_rsp_fault,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [XLEN-1:0] lsu_addr,
    input  logic [1:0]      lsu_oper,
    input  logic [1:0]      lsu_size,
    input  logic [1:0]      lsu_priv,
    output logic            lsu_rsp_valid,
    output logic            lsu_rsp_fault,
    input  logic            csr_req,
    input  logic [XLEN-1:0] csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic            csr_ack,
    output logic [XLEN-1:0] pmp_addr,
    output logic [1:0]      pmp_oper,
    output logic [1:0]      pmp_size,
    output logic [1:0]      pmp_priv,
    output logic            pmp_wr_en,
    output logic [XLEN-1:0] pmp_rw_addr,
    output logic [XLEN-1:0] pmp_wdata,
    input  logic [1:0]      pmp_permission
);

    pmp_sched_state_e state;
    req_id_e          owner;
    logic             gnt_if;
    logic             gnt_lsu;

    // CSR writes pre-empt arbitration, and nothing is granted outside IDLE.
    rr_arb2 u_arb (
        .clock   (clock),
        .reset   (reset),
        .req_if  (if_valid),
        .req_lsu (lsu_valid),
        .block   (csr_req || (state != IDLE)),
        .gnt_if  (gnt_if),
        .gnt_lsu (gnt_lsu)
    );

    assign if_ready  = gnt_if;
    assign lsu_ready = gnt_lsu;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= IDLE;
            owner         <= REQ_IF;
            if_rsp_valid  <= 1'b0;
            if_rsp_fault  <= 1'b0;
            lsu_rsp_valid <= 1'b0;
            lsu_rsp_fault <= 1'b0;
            csr_ack       <= 1'b0;
            pmp_addr      <= '0;
            pmp_oper      <= READ;
            pmp_size      <= '0;
            pmp_priv      <= '0;
            pmp_wr_en     <= 1'b0;
            pmp_rw_addr   <= '0;
            pmp_wdata     <= '0;
        end else begin
            if_rsp_valid  <= 1'b0;
            lsu_rsp_valid <= 1'b0;
            csr_ack       <= 1'b0;
            pmp_wr_en     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (csr_req) begin
                        state       <= CSR_WR;
                        pmp_wr_en   <= 1'b1;
                        pmp_rw_addr <= csr_addr;
                        pmp_wdata   <= csr_wdata;
                    end else if (gnt_if) begin
                        state    <= CHECK;
                        owner    <= REQ_IF;
                        pmp_addr <= if_addr;
                        pmp_oper <= EXECUTE;
                        pmp_size <= 2'b10;
                        pmp_priv <= if_priv;
                    end else if (gnt_lsu) begin
                        state    <= CHECK;
                        owner    <= REQ_LSU;
                        pmp_addr <= lsu_addr;
                        pmp_oper <= lsu_oper;
                        pmp_size <= lsu_size;
                        pmp_priv <= lsu_priv;
                    end
                end
                CHECK: begin
                    state <= IDLE;
                    if (owner == REQ_IF) begin
                        if_rsp_valid <= 1'b1;
                        if_rsp_fault <= (pmp_permission != PMP_PERM_ALLOW);
                    end else begin
                        lsu_rsp_valid <= 1'b1;
                        lsu_rsp_fault <= (pmp_permission != PMP_PERM_ALLOW);
                    end
                end
                CSR_WR: begin
                    state <= CSR_SETTLE;
                end
                CSR_SETTLE: begin
                    state   <= IDLE;
                    csr_ack <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pmp_req_sched.sv
// Bench for pmp_req_sched: directed scenarios plus a randomized run against a
// transaction-level model (busy-until timer, response due times, round-robin winner).
module tb_pmp_req_sched;
    import cep_define::*;

    localparam int XLEN = 32;

    logic            clock = 1'b0;
    logic            reset;
    logic            if_valid, if_ready, if_rsp_valid, if_rsp_fault;
    logic [XLEN-1:0] if_addr;
    logic [1:0]      if_priv;
    logic            lsu_valid, lsu_ready, lsu_rsp_valid, lsu_rsp_fault;
    logic [XLEN-1:0] lsu_addr;
    logic [1:0]      lsu_oper, lsu_size, lsu_priv;
    logic            csr_req, csr_ack;
    logic [XLEN-1:0] csr_addr, csr_wdata;
    logic [XLEN-1:0] pmp_addr, pmp_rw_addr, pmp_wdata;
    logic [1:0]      pmp_oper, pmp_size, pmp_priv, pmp_permission;
    logic            pmp_wr_en;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    pmp_req_sched #(.XLEN(XLEN)) dut (
        .clock(clock), .reset(reset),
        .if_valid(if_valid), .if_ready(if_ready), .if_addr(if_addr), .if_priv(if_priv),
        .if_rsp_valid(if_rsp_valid), .if_rsp_fault(if_rsp_fault),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_addr(lsu_addr),
        .lsu_oper(lsu_oper), .lsu_size(lsu_size), .lsu_priv(lsu_priv),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_fault(lsu_rsp_fault),
        .csr_req(csr_req), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_ack(csr_ack),
        .pmp_addr(pmp_addr), .pmp_oper(pmp_oper), .pmp_size(pmp_size), .pmp_priv(pmp_priv),
        .pmp_wr_en(pmp_wr_en), .pmp_rw_addr(pmp_rw_addr), .pmp_wdata(pmp_wdata),
        .pmp_permission(pmp_permission)
    );

    // Stand-in checker: allowed only when both bits are set.
    function automatic logic [1:0] perm_of(input logic [31:0] a, input logic [1:0] o,
                                           input logic [1:0] s, input logic [1:0] p);
        return {~(a[6] ^ s[0] ^ o[0]), ~(a[7] ^ a[8] ^ p[1])};
    endfunction

    assign pmp_permission = perm_of(pmp_addr, pmp_oper, pmp_size, pmp_priv);

    task automatic drive_idle();
        reset = 1'b1; if_valid = 1'b0; lsu_valid = 1'b0; csr_req = 1'b0;
        if_addr = '0; if_priv = '0; lsu_addr = '0; lsu_oper = '0; lsu_size = '0; lsu_priv = '0;
        csr_addr = '0; csr_wdata = '0;
    endtask

    task automatic test_reset();
        logic [13:0] ctl;
        drive_idle(); reset = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        ctl = {if_ready, if_rsp_valid, if_rsp_fault, lsu_ready, lsu_rsp_valid, lsu_rsp_fault,
               csr_ack, pmp_wr_en, pmp_oper, pmp_size, pmp_priv};
        checks++; if (ctl !== 14'b0) begin errors++; $display("FAIL reset_ctl got %b want 0", ctl); end
        checks++;
        if ({pmp_addr, pmp_rw_addr, pmp_wdata} !== 96'b0) begin
            errors++; $display("FAIL reset_data got %h/%h/%h want 0", pmp_addr, pmp_rw_addr, pmp_wdata);
        end
        reset = 1'b1;
    endtask

    task automatic test_if_single();
        @(negedge clock); if_valid = 1'b1; if_addr = 32'h0000_1000; if_priv = 2'b01;
        #1; checks++;
        if (if_ready !== 1'b1 || lsu_ready !== 1'b0) begin
            errors++; $display("FAIL if_single_ready got %b%b want 10", if_ready, lsu_ready);
        end
        @(negedge clock); if_valid = 1'b0; if_addr = 32'hFFFF_FFC0;
        checks++; if (pmp_oper !== EXECUTE) begin errors++; $display("FAIL if_single_oper got %b want 10", pmp_oper); end
        checks++;
        if (pmp_addr !== 32'h0000_1000 || pmp_size !== 2'b10 || pmp_priv !== 2'b01) begin
            errors++; $display("FAIL if_single_drive got %h/%b/%b want 1000/10/01", pmp_addr, pmp_size, pmp_priv);
        end
        checks++; if (if_rsp_valid !== 1'b0) begin errors++; $display("FAIL if_single_early got 1 want 0"); end
        @(negedge clock);
        checks++;
        if (if_rsp_valid !== 1'b1 || if_rsp_fault !== 1'b0) begin
            errors++; $display("FAIL if_single_rsp got v=%b f=%b want v=1 f=0", if_rsp_valid, if_rsp_fault);
        end
        checks++;
        if ({lsu_ready, lsu_rsp_valid, lsu_rsp_fault} !== 3'b000) begin
            errors++; $display("FAIL if_single_lsu_idle got %b want 000", {lsu_ready, lsu_rsp_valid, lsu_rsp_fault});
        end
        @(negedge clock);
        checks++; if (if_rsp_valid !== 1'b0) begin errors++; $display("FAIL if_single_pulse got 1 want 0"); end
        if_addr = '0;
    endtask

    task automatic test_round_robin();
        int n_rsp = 0;
        logic [3:0] exp_v;
        @(negedge clock); reset = 1'b0;
        @(negedge clock); reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if_valid = (c < 8); lsu_valid = (c < 8); lsu_oper = READ;
            #1;
            exp_v = {(c < 8) && (c % 4 == 0), (c < 8) && (c % 4 == 2), (c == 2 || c == 6), (c == 4 || c == 8)};
            checks++;
            if ({if_ready, lsu_ready, if_rsp_valid, lsu_rsp_valid} !== exp_v) begin
                errors++; $display("FAIL round_robin c=%0d got %b want %b", c,
                                   {if_ready, lsu_ready, if_rsp_valid, lsu_rsp_valid}, exp_v);
            end
            n_rsp += int'(if_rsp_valid) + int'(lsu_rsp_valid);
        end
        checks++; if (n_rsp != 4) begin errors++; $display("FAIL round_robin_count got %0d want 4", n_rsp); end
    endtask

    task automatic test_fault();
        @(negedge clock); lsu_valid = 1'b1; lsu_addr = 32'h0000_2000; lsu_oper = WRITE; lsu_size = 2'b00; lsu_priv = 2'b11;
        #1; checks++; if (lsu_ready !== 1'b1) begin errors++; $display("FAIL fault_ready got 0 want 1"); end
        @(negedge clock); lsu_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (lsu_rsp_valid !== 1'b1 || lsu_rsp_fault !== 1'b1) begin
            errors++; $display("FAIL fault_deny got v=%b f=%b want v=1 f=1", lsu_rsp_valid, lsu_rsp_fault);
        end
        checks++; if (if_rsp_fault !== 1'b0) begin errors++; $display("FAIL fault_if_hold got 1 want 0"); end
        lsu_valid = 1'b1; lsu_oper = READ; lsu_priv = 2'b00;
        #1; checks++; if (lsu_ready !== 1'b1) begin errors++; $display("FAIL fault_ready2 got 0 want 1"); end
        @(negedge clock); lsu_valid = 1'b0;
        checks++; if (lsu_rsp_fault !== 1'b1) begin errors++; $display("FAIL fault_hold got 0 want 1"); end
        @(negedge clock);
        checks++;
        if (lsu_rsp_valid !== 1'b1 || lsu_rsp_fault !== 1'b0) begin
            errors++; $display("FAIL fault_allow got v=%b f=%b want v=1 f=0", lsu_rsp_valid, lsu_rsp_fault);
        end
        lsu_addr = '0;
    endtask

    task automatic test_csr_with_both();
        @(negedge clock);
        csr_req = 1'b1; csr_addr = {20'b0, CSR_PMPADDR0}; csr_wdata = 32'h1234_5678;
        if_valid = 1'b1; lsu_valid = 1'b1; lsu_oper = READ;
        #1; checks++; if ({if_ready, lsu_ready} !== 2'b00) begin errors++; $display("FAIL csr_no_ready0 got %b want 00", {if_ready, lsu_ready}); end
        @(negedge clock);
        checks++;
        if (pmp_wr_en !== 1'b1 || pmp_rw_addr !== 32'h0000_03B0 || pmp_wdata !== 32'h1234_5678) begin
            errors++; $display("FAIL csr_write got en=%b a=%h d=%h want en=1 a=3b0 d=12345678", pmp_wr_en, pmp_rw_addr, pmp_wdata);
        end
        #1; checks++; if ({if_ready, lsu_ready} !== 2'b00) begin errors++; $display("FAIL csr_no_ready1 got %b want 00", {if_ready, lsu_ready}); end
        @(negedge clock);
        checks++;
        if ({pmp_wr_en, csr_ack, if_ready, lsu_ready} !== 4'b0000) begin
            errors++; $display("FAIL csr_settle got %b want 0000", {pmp_wr_en, csr_ack, if_ready, lsu_ready});
        end
        @(negedge clock);
        checks++;
        if (csr_ack !== 1'b1 || pmp_wr_en !== 1'b0) begin
            errors++; $display("FAIL csr_ack got ack=%b en=%b want ack=1 en=0", csr_ack, pmp_wr_en);
        end
        csr_req = 1'b0;
        #1; checks++; if ({if_ready, lsu_ready} !== 2'b10) begin errors++; $display("FAIL csr_then_if got %b want 10", {if_ready, lsu_ready}); end
        @(negedge clock); if_valid = 1'b0;
        checks++; if (csr_ack !== 1'b0) begin errors++; $display("FAIL csr_ack_pulse got 1 want 0"); end
        @(negedge clock);
        checks++; if (if_rsp_valid !== 1'b1) begin errors++; $display("FAIL csr_if_rsp got 0 want 1"); end
        #1; checks++; if (lsu_ready !== 1'b1) begin errors++; $display("FAIL csr_then_lsu got 0 want 1"); end
        @(negedge clock); lsu_valid = 1'b0;
        @(negedge clock);
        checks++; if (lsu_rsp_valid !== 1'b1) begin errors++; $display("FAIL csr_lsu_rsp got 0 want 1"); end
    endtask

    task automatic test_csr_during_check();
        @(negedge clock); if_valid = 1'b1; if_addr = 32'h0000_0040;
        #1; checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL cdc_ready got 0 want 1"); end
        @(negedge clock); if_valid = 1'b0; csr_req = 1'b1; csr_addr = {20'b0, CSR_PMPCFG0}; csr_wdata = 32'h0000_001F;
        #1; checks++;
        if ({if_ready, lsu_ready, pmp_wr_en} !== 3'b000) begin
            errors++; $display("FAIL cdc_in_check got %b want 000", {if_ready, lsu_ready, pmp_wr_en});
        end
        @(negedge clock);
        checks++;
        if ({if_rsp_valid, if_rsp_fault, pmp_wr_en} !== 3'b110) begin
            errors++; $display("FAIL cdc_rsp_first got %b want 110", {if_rsp_valid, if_rsp_fault, pmp_wr_en});
        end
        @(negedge clock);
        checks++;
        if (pmp_wr_en !== 1'b1 || pmp_rw_addr !== 32'h0000_03A0) begin
            errors++; $display("FAIL cdc_write got en=%b a=%h want en=1 a=3a0", pmp_wr_en, pmp_rw_addr);
        end
        @(negedge clock);
        checks++; if (pmp_wr_en !== 1'b0) begin errors++; $display("FAIL cdc_settle got 1 want 0"); end
        @(negedge clock);
        checks++; if (csr_ack !== 1'b1) begin errors++; $display("FAIL cdc_ack got 0 want 1"); end
        csr_req = 1'b0; if_addr = '0;
    endtask

    task automatic test_reset_mid();
        logic [13:0] ctl;
        @(negedge clock); if_valid = 1'b1;
        @(negedge clock); if_valid = 1'b0; reset = 1'b0;
        @(negedge clock); reset = 1'b1;
        ctl = {if_ready, if_rsp_valid, if_rsp_fault, lsu_ready, lsu_rsp_valid, lsu_rsp_fault,
               csr_ack, pmp_wr_en, pmp_oper, pmp_size, pmp_priv};
        checks++; if (ctl !== 14'b0) begin errors++; $display("FAIL rst_check_ctl got %b want 0", ctl); end
        @(negedge clock);
        checks++; if ({if_rsp_valid, lsu_rsp_valid} !== 2'b00) begin errors++; $display("FAIL rst_check_norsp got %b want 00", {if_rsp_valid, lsu_rsp_valid}); end
        csr_req = 1'b1; csr_addr = {20'b0, CSR_PMPADDR0}; csr_wdata = 32'hCAFE_0001;
        @(negedge clock);
        checks++; if (pmp_wr_en !== 1'b1) begin errors++; $display("FAIL rst_wr_pre got 0 want 1"); end
        reset = 1'b0; csr_req = 1'b0;
        @(negedge clock); reset = 1'b1;
        checks++;
        if ({pmp_wr_en, csr_ack} !== 2'b00 || {pmp_addr, pmp_rw_addr, pmp_wdata} !== 96'b0) begin
            errors++; $display("FAIL rst_wr_zero got en=%b ack=%b a=%h d=%h want 0", pmp_wr_en, csr_ack, pmp_rw_addr, pmp_wdata);
        end
        @(negedge clock);
        checks++; if (csr_ack !== 1'b0) begin errors++; $display("FAIL rst_wr_noack1 got 1 want 0"); end
        @(negedge clock);
        checks++; if (csr_ack !== 1'b0) begin errors++; $display("FAIL rst_wr_noack2 got 1 want 0"); end
        if_valid = 1'b1; lsu_valid = 1'b1;
        #1; checks++; if ({if_ready, lsu_ready} !== 2'b10) begin errors++; $display("FAIL rst_tie got %b want 10", {if_ready, lsu_ready}); end
        @(negedge clock); drive_idle();
        repeat (3) @(negedge clock);
    endtask

    task automatic test_random();
        int free_at = 0, if_due = -1, lsu_due = -1, wr_due = -1, ack_due = -1;
        logic if_pend = 0, lsu_pend = 0, csr_pend = 0;
        logic if_fe = 0, lsu_fe = 0, if_fn = 0, lsu_fn = 0;
        logic g_if, g_lsu, idle, acked;
        logic [31:0] wa_e = '0, wd_e = '0;
        req_id_e mlast = REQ_LSU;
        @(negedge clock); drive_idle(); reset = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clock);
            checks++; if (if_rsp_valid !== (cyc == if_due)) begin errors++; $display("FAIL rnd_if_rsp c=%0d got %b want %b", cyc, if_rsp_valid, cyc == if_due); end
            if (cyc == if_due) if_fe = if_fn;
            checks++; if (if_rsp_fault !== if_fe) begin errors++; $display("FAIL rnd_if_fault c=%0d got %b want %b", cyc, if_rsp_fault, if_fe); end
            checks++; if (lsu_rsp_valid !== (cyc == lsu_due)) begin errors++; $display("FAIL rnd_lsu_rsp c=%0d got %b want %b", cyc, lsu_rsp_valid, cyc == lsu_due); end
            if (cyc == lsu_due) lsu_fe = lsu_fn;
            checks++; if (lsu_rsp_fault !== lsu_fe) begin errors++; $display("FAIL rnd_lsu_fault c=%0d got %b want %b", cyc, lsu_rsp_fault, lsu_fe); end
            checks++; if (pmp_wr_en !== (cyc == wr_due)) begin errors++; $display("FAIL rnd_wr_en c=%0d got %b want %b", cyc, pmp_wr_en, cyc == wr_due); end
            if (cyc == wr_due) begin
                checks++;
                if ({pmp_rw_addr, pmp_wdata} !== {wa_e, wd_e}) begin
                    errors++; $display("FAIL rnd_wr_data c=%0d got %h/%h want %h/%h", cyc, pmp_rw_addr, pmp_wdata, wa_e, wd_e);
                end
            end
            checks++; if (csr_ack !== (cyc == ack_due)) begin errors++; $display("FAIL rnd_ack c=%0d got %b want %b", cyc, csr_ack, cyc == ack_due); end
            acked = (cyc == ack_due);
            if (acked) csr_pend = 1'b0;
            if ($urandom_range(0, 59) == 0) begin
                drive_idle(); reset = 1'b0;
                if_pend = 1'b0; lsu_pend = 1'b0; csr_pend = 1'b0; if_fe = 1'b0; lsu_fe = 1'b0;
                mlast = REQ_LSU; free_at = cyc + 1;
                if_due = -1; lsu_due = -1; wr_due = -1; ack_due = -1;
                continue;
            end
            reset = 1'b1;
            if (!if_pend && $urandom_range(0, 1) == 1) if_pend = 1'b1;
            if (!lsu_pend && $urandom_range(0, 1) == 1) lsu_pend = 1'b1;
            if (!csr_pend && !acked && $urandom_range(0, 11) == 0) begin
                csr_pend = 1'b1;
                csr_addr = {20'b0, CSR_PMPADDR0} + 32'($urandom_range(0, 15));
                csr_wdata = $urandom;
            end
            if_addr = $urandom; if_priv = 2'($urandom);
            lsu_addr = $urandom; lsu_oper = 2'($urandom_range(0, 1)); lsu_size = 2'($urandom); lsu_priv = 2'($urandom);
            if_valid = if_pend; lsu_valid = lsu_pend; csr_req = csr_pend;
            #1;
            idle = (cyc >= free_at);
            g_if = 1'b0; g_lsu = 1'b0;
            if (idle && !csr_pend) begin
                if (if_pend && lsu_pend) begin
                    g_if = (mlast == REQ_LSU); g_lsu = !g_if;
                end else begin
                    g_if = if_pend; g_lsu = lsu_pend;
                end
            end
            checks++;
            if ({if_ready, lsu_ready} !== {g_if, g_lsu}) begin
                errors++; $display("FAIL rnd_ready c=%0d got %b want %b", cyc, {if_ready, lsu_ready}, {g_if, g_lsu});
            end
            if (idle && csr_pend) begin
                wr_due = cyc + 1; ack_due = cyc + 3; free_at = cyc + 3; wa_e = csr_addr; wd_e = csr_wdata;
            end else if (g_if) begin
                if_due = cyc + 2; free_at = cyc + 2; mlast = REQ_IF; if_pend = 1'b0;
                if_fn = (perm_of(if_addr, EXECUTE, 2'b10, if_priv) != PMP_PERM_ALLOW);
            end else if (g_lsu) begin
                lsu_due = cyc + 2; free_at = cyc + 2; mlast = REQ_LSU; lsu_pend = 1'b0;
                lsu_fn = (perm_of(lsu_addr, lsu_oper, lsu_size, lsu_priv) != PMP_PERM_ALLOW);
            end
        end
        @(negedge clock); drive_idle();
    endtask

    initial begin
        drive_idle(); reset = 1'b0;
        test_reset();
        test_if_single();
        test_round_robin();
        test_fault();
        test_csr_with_both();
        test_csr_during_check();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
